// File: rtl/bp_resolve.sv
// Branch resolution unit: carries fetch-time predictions through the D/E registers,
// checks them in E, raises flush/redirect, and emits the registered table-update packet.
module bp_resolve #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 f_valid,
  input  logic [WIDTH-1:0]     f_pc,
  input  logic                 f_pred_taken,
  input  logic [WIDTH-1:0]     f_pred_target,
  input  logic                 stall,
  input  logic                 ex_is_branch,
  input  logic                 ex_is_jump,
  input  logic                 ex_taken,
  input  logic [WIDTH-1:0]     ex_target,
  output logic                 flush,
  output logic [WIDTH-1:0]     redirect_pc,
  output logic [WIDTH-1:0]     pc_tu,
  output logic [WIDTH-1:0]     pcplusimm_tu,
  output logic                 eq,
  output logic                 cu_branch,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(32'd4);

  // Sequential PC; the add wraps naturally at 2^WIDTH.
  function automatic logic [WIDTH-1:0] pc_plus4(input logic [WIDTH-1:0] pc);
    return pc + PC_STEP;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    logic [CNT_WIDTH-1:0] res;
    if (&cnt) begin
      res = cnt;
    end else begin
      res = cnt + CNT_WIDTH'(1'b1);
    end
    return res;
  endfunction

  logic             d_valid_r;
  logic [WIDTH-1:0] d_pc_r;
  logic             d_pred_taken_r;
  logic [WIDTH-1:0] d_pred_target_r;
  logic             e_valid_r;
  logic [WIDTH-1:0] e_pc_r;
  logic             e_pred_taken_r;
  logic [WIDTH-1:0] e_pred_target_r;

  logic             cu_branch_r;
  logic [WIDTH-1:0] pc_tu_r;
  logic [WIDTH-1:0] pcplusimm_tu_r;
  logic             eq_r;
  logic [CNT_WIDTH-1:0] branch_cnt_r;
  logic [CNT_WIDTH-1:0] mispred_cnt_r;

  logic             resolve_s;
  logic             ctrl_s;
  logic             act_taken_s;
  logic [WIDTH-1:0] e_seq_pc_s;
  logic [WIDTH-1:0] act_next_s;
  logic [WIDTH-1:0] pred_next_s;
  logic             mispredict_s;
  logic             flush_s;
  logic             upd_s;

  // E-stage resolution: compare predicted and actual next PC.
  always_comb begin
    resolve_s    = e_valid_r & ~stall;
    ctrl_s       = ex_is_branch | ex_is_jump;
    // A jump always wins, which also covers the illegal branch+jump encoding.
    act_taken_s  = ex_is_jump | (ex_is_branch & ex_taken);
    e_seq_pc_s   = pc_plus4(e_pc_r);
    act_next_s   = act_taken_s ? ex_target : e_seq_pc_s;
    pred_next_s  = e_pred_taken_r ? e_pred_target_r : e_seq_pc_s;
    mispredict_s = (act_next_s != pred_next_s);
    flush_s      = resolve_s & mispredict_s;
    upd_s        = resolve_s & ctrl_s;
  end

  assign flush       = flush_s;
  assign redirect_pc = flush_s ? act_next_s : '0;

  // D/E pipeline registers; a flush kills the younger D and incoming F slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid_r       <= 1'b0;
      d_pc_r          <= '0;
      d_pred_taken_r  <= 1'b0;
      d_pred_target_r <= '0;
      e_valid_r       <= 1'b0;
      e_pc_r          <= '0;
      e_pred_taken_r  <= 1'b0;
      e_pred_target_r <= '0;
    end else if (!stall) begin
      if (flush_s) begin
        d_valid_r <= 1'b0;
        e_valid_r <= 1'b0;
      end else begin
        d_valid_r <= f_valid;
        e_valid_r <= d_valid_r;
      end
      d_pc_r          <= f_pc;
      d_pred_taken_r  <= f_pred_taken;
      d_pred_target_r <= f_pred_target;
      e_pc_r          <= d_pc_r;
      e_pred_taken_r  <= d_pred_taken_r;
      e_pred_target_r <= d_pred_target_r;
    end
  end

  // Table-update packet: one-cycle valid pulse, data fields hold between updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cu_branch_r    <= 1'b0;
      pc_tu_r        <= '0;
      pcplusimm_tu_r <= '0;
      eq_r           <= 1'b0;
    end else begin
      cu_branch_r <= upd_s;
      if (upd_s) begin
        pc_tu_r        <= e_pc_r;
        pcplusimm_tu_r <= ex_target;
        eq_r           <= act_taken_s;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_r  <= '0;
      mispred_cnt_r <= '0;
    end else begin
      if (upd_s) begin
        branch_cnt_r <= sat_inc(branch_cnt_r);
      end
      if (flush_s) begin
        mispred_cnt_r <= sat_inc(mispred_cnt_r);
      end
    end
  end

  assign cu_branch    = cu_branch_r;
  assign pc_tu        = pc_tu_r;
  assign pcplusimm_tu = pcplusimm_tu_r;
  assign eq           = eq_r;
  assign branch_cnt   = branch_cnt_r;
  assign mispred_cnt  = mispred_cnt_r;

endmodule

// File: tb/tb_bp_resolve.sv
// Directed bench for bp_resolve; narrow counters so saturation is reachable quickly.
module tb_bp_resolve;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          f_valid;
  logic [W-1:0]  f_pc;
  logic          f_pred_taken;
  logic [W-1:0]  f_pred_target;
  logic          stall;
  logic          ex_is_branch;
  logic          ex_is_jump;
  logic          ex_taken;
  logic [W-1:0]  ex_target;
  logic          flush;
  logic [W-1:0]  redirect_pc;
  logic [W-1:0]  pc_tu;
  logic [W-1:0]  pcplusimm_tu;
  logic          eq;
  logic          cu_branch;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] mispred_cnt;

  int total;
  int bad;

  bp_resolve #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_pc(f_pc), .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
    .stall(stall),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .pc_tu(pc_tu), .pcplusimm_tu(pcplusimm_tu), .eq(eq), .cu_branch(cu_branch),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_ex();
    ex_is_branch = 1'b0;
    ex_is_jump   = 1'b0;
    ex_taken     = 1'b0;
    ex_target    = '0;
  endtask

  // Fetch one instruction, bring it to E, drive its outcome and check flush/redirect.
  task automatic run_one(input string tag, input logic [W-1:0] pc, input logic pt,
                         input logic [W-1:0] ptgt, input logic br, input logic jmp,
                         input logic tk, input logic [W-1:0] tgt,
                         input logic exp_fl, input logic [W-1:0] exp_rd);
    f_valid = 1'b1; f_pc = pc; f_pred_taken = pt; f_pred_target = ptgt;
    tick();
    f_valid = 1'b0;
    tick();
    ex_is_branch = br; ex_is_jump = jmp; ex_taken = tk; ex_target = tgt;
    #1;
    chk({tag, ".flush"}, 64'(flush), 64'(exp_fl));
    chk({tag, ".redirect"}, 64'(redirect_pc), 64'(exp_rd));
    tick();
    clear_ex();
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; stall = 1'b0;
    f_valid = 1'b0; f_pc = '0; f_pred_taken = 1'b0; f_pred_target = '0;
    clear_ex();
    #1;
    chk("rst.flush", 64'(flush), 64'd0);
    chk("rst.redirect", 64'(redirect_pc), 64'd0);
    chk("rst.cu_branch", 64'(cu_branch), 64'd0);
    chk("rst.pc_tu", 64'(pc_tu), 64'd0);
    chk("rst.bcnt", 64'(branch_cnt), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Not-taken branch, predicted not-taken
    run_one("nt", 32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h140, 1'b0, 32'h0);
    chk("nt.cu_branch", 64'(cu_branch), 64'd1);
    chk("nt.pc_tu", 64'(pc_tu), 64'h100);
    chk("nt.pcplusimm", 64'(pcplusimm_tu), 64'h140);
    chk("nt.eq", 64'(eq), 64'd0);
    chk("nt.bcnt", 64'(branch_cnt), 64'd1);
    chk("nt.mcnt", 64'(mispred_cnt), 64'd0);

    // Taken branch predicted not-taken, with younger false-hit instructions behind it
    f_valid = 1'b1; f_pc = 32'h200; f_pred_taken = 1'b0; f_pred_target = 32'h0;
    tick();
    f_pc = 32'h204; f_pred_taken = 1'b1; f_pred_target = 32'h900;
    tick();
    f_pc = 32'h208; f_pred_taken = 1'b1; f_pred_target = 32'h900;
    ex_is_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h240;
    #1;
    chk("tk.flush", 64'(flush), 64'd1);
    chk("tk.redirect", 64'(redirect_pc), 64'h240);
    tick();
    f_valid = 1'b0;
    clear_ex();
    #1;
    chk("tk.kill_d", 64'(flush), 64'd0);
    chk("tk.cu_branch", 64'(cu_branch), 64'd1);
    chk("tk.pc_tu", 64'(pc_tu), 64'h200);
    chk("tk.pcplusimm", 64'(pcplusimm_tu), 64'h240);
    chk("tk.eq", 64'(eq), 64'd1);
    chk("tk.mcnt", 64'(mispred_cnt), 64'd1);
    chk("tk.bcnt", 64'(branch_cnt), 64'd2);
    tick();
    chk("tk.kill_f", 64'(flush), 64'd0);
    chk("tk.cu_once", 64'(cu_branch), 64'd0);

    // Predicted taken: correct target, then wrong target
    run_one("pt_ok", 32'h400, 1'b1, 32'h440, 1'b1, 1'b0, 1'b1, 32'h440, 1'b0, 32'h0);
    chk("pt_ok.mcnt", 64'(mispred_cnt), 64'd1);
    run_one("pt_bad", 32'h200, 1'b1, 32'h244, 1'b1, 1'b0, 1'b1, 32'h240, 1'b1, 32'h240);
    chk("pt_bad.mcnt", 64'(mispred_cnt), 64'd2);
    chk("pt_bad.bcnt", 64'(branch_cnt), 64'd4);

    // False BTB hit on an ALU op
    run_one("fh", 32'h300, 1'b1, 32'h380, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h304);
    chk("fh.cu_branch", 64'(cu_branch), 64'd0);
    chk("fh.bcnt", 64'(branch_cnt), 64'd4);
    chk("fh.mcnt", 64'(mispred_cnt), 64'd3);
    chk("fh.pc_tu_hold", 64'(pc_tu), 64'h200);

    // Jump predicted not-taken, then branch+jump encoding resolving as a jump
    run_one("jmp", 32'h600, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h700, 1'b1, 32'h700);
    chk("jmp.eq", 64'(eq), 64'd1);
    run_one("both", 32'h680, 1'b1, 32'h800, 1'b1, 1'b1, 1'b0, 32'h800, 1'b0, 32'h0);
    chk("both.eq", 64'(eq), 64'd1);
    chk("both.mcnt", 64'(mispred_cnt), 64'd4);

    // PC+4 wraps: predicted target 0 matches fall-through of 0xFFFFFFFC
    run_one("wrap", 32'hFFFF_FFFC, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 32'h0);
    chk("wrap.bcnt", 64'(branch_cnt), 64'd7);

    // Mispredicting branch held in E by stall
    f_valid = 1'b1; f_pc = 32'hA00; f_pred_taken = 1'b0; f_pred_target = 32'h0;
    tick();
    f_valid = 1'b0;
    tick();
    stall = 1'b1;
    ex_is_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'hA80;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.flush", 64'(flush), 64'd0);
      chk("stall.cu_branch", 64'(cu_branch), 64'd0);
      tick();
    end
    stall = 1'b0;
    #1;
    chk("stall.rel_flush", 64'(flush), 64'd1);
    chk("stall.rel_redirect", 64'(redirect_pc), 64'hA80);
    tick();
    clear_ex();
    chk("stall.cu_branch1", 64'(cu_branch), 64'd1);
    chk("stall.pc_tu", 64'(pc_tu), 64'hA00);
    chk("stall.mcnt", 64'(mispred_cnt), 64'd5);
    chk("stall.bcnt", 64'(branch_cnt), 64'd8);
    tick();
    chk("stall.cu_branch0", 64'(cu_branch), 64'd0);

    // Back-to-back correctly predicted branches; branch counter saturates
    ex_is_branch = 1'b1; ex_taken = 1'b0; ex_target = 32'h50;
    for (int k = 0; k < 10; k++) begin
      f_valid = 1'b1; f_pc = 32'hB00 + 32'(4 * k); f_pred_taken = 1'b0;
      tick();
      if (k >= 2) begin
        chk("b2b.cu_branch", 64'(cu_branch), 64'd1);
        chk("b2b.pc_tu", 64'(pc_tu), 64'(32'hB00 + 32'(4 * (k - 2))));
      end
    end
    f_valid = 1'b0;
    tick();
    tick();
    chk("sat.pc_tu", 64'(pc_tu), 64'hB24);
    chk("sat.bcnt", 64'(branch_cnt), 64'd15);
    chk("sat.mcnt", 64'(mispred_cnt), 64'd5);
    clear_ex();
    tick();

    // Async reset between resolution and update
    f_valid = 1'b1; f_pc = 32'hC00; f_pred_taken = 1'b0;
    tick();
    f_valid = 1'b0;
    tick();
    ex_is_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'hC40;
    #1;
    chk("ar.flush_pre", 64'(flush), 64'd1);
    rst = 1'b1;
    #1;
    chk("ar.flush", 64'(flush), 64'd0);
    chk("ar.redirect", 64'(redirect_pc), 64'd0);
    chk("ar.bcnt", 64'(branch_cnt), 64'd0);
    chk("ar.mcnt", 64'(mispred_cnt), 64'd0);
    chk("ar.pc_tu", 64'(pc_tu), 64'd0);
    chk("ar.pcplusimm", 64'(pcplusimm_tu), 64'd0);
    tick();
    chk("ar.cu_branch_rst", 64'(cu_branch), 64'd0);
    rst = 1'b0;
    clear_ex();
    tick();
    chk("ar.cu_branch_post", 64'(cu_branch), 64'd0);
    chk("ar.bcnt_post", 64'(branch_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
